ifm_buf_responder: RTL and testbench

IFM_BUF_RESPONDER -- requirements
Module: ifm_buf_responder

---
 rtl/ifm_buf_responder.sv | 164 ++++++++++++++++
 tb/tb_ifm_buf_responder.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_buf_responder.sv
// IFM buffer responder: serves K-lane PE requests from IFM_BUF_CNT row banks with a fixed 3-cycle latency.
// Optional zero padding of out-of-frame lanes is compiled in when IFM_BUF_PAD_EN is defined.
module ifm_buf_responder #(
    parameter int K            = 3,
    parameter int W_SIZE       = 10,
    parameter int W_CHANNEL    = 10,
    parameter int W_FRAME_SIZE = 14,
    parameter int IFM_DW       = 32,
    parameter int IFM_BUF_CNT  = 4,
    parameter int W_IFM_BUF    = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [W_SIZE-1:0]                 q_width,
    input  logic [W_SIZE-1:0]                 q_height,
    input  logic [W_CHANNEL-1:0]              q_chn_words,
    input  logic                              i_ifm_req_vld,
    input  logic [K*W_SIZE-1:0]               i_ifm_req_row,
    input  logic [K*W_SIZE-1:0]               i_ifm_req_col,
    input  logic [K*W_CHANNEL-1:0]            i_ifm_req_chn,
    output logic [IFM_BUF_CNT-1:0]            o_buf_en,
    output logic [IFM_BUF_CNT*W_FRAME_SIZE-1:0] o_buf_addr,
    input  logic [IFM_BUF_CNT*IFM_DW-1:0]     i_buf_rdata,
    output logic                              o_ifm_data_vld,
    output logic [K*IFM_DW-1:0]               o_ifm_data,
    output logic                              o_conflict
);

    // Request decode (cycle T)
    logic [W_IFM_BUF-1:0]    lane_bank [K];
    logic [W_FRAME_SIZE-1:0] lane_addr [K];
    logic [K-1:0]            lane_pad;

    // Stage 1: bank read issue (T+1)
    logic                    s1_vld_q;
    logic [IFM_BUF_CNT-1:0]  buf_en_q;
    logic [W_FRAME_SIZE-1:0] buf_addr_q [IFM_BUF_CNT];
    logic [W_IFM_BUF-1:0]    s1_bank_q [K];
    logic [K-1:0]            s1_pad_q;

    // Stage 2: read data returning (T+2)
    logic                    s2_vld_q;
    logic [W_IFM_BUF-1:0]    s2_bank_q [K];
    logic [K-1:0]            s2_pad_q;

    // Stage 3: response (T+3)
    logic                    data_vld_q;
    logic [K*IFM_DW-1:0]     data_q;
    logic [K*IFM_DW-1:0]     data_d;
    logic                    conflict_q;

    logic [IFM_BUF_CNT-1:0]  bank_en_d;
    logic [W_FRAME_SIZE-1:0] bank_addr_d [IFM_BUF_CNT];
    logic                    conflict_d;

    genvar gi;

    generate
        for (gi = 0; gi < K; gi++) begin : g_lane
            logic [W_SIZE-1:0]    col;
            logic [W_CHANNEL-1:0] chn;

            assign col = i_ifm_req_col[gi*W_SIZE +: W_SIZE];
            assign chn = i_ifm_req_chn[gi*W_CHANNEL +: W_CHANNEL];
            assign lane_bank[gi] = i_ifm_req_row[gi*W_SIZE +: W_IFM_BUF];
            // Modular arithmetic at the bank address width gives the truncated address directly.
            assign lane_addr[gi] = W_FRAME_SIZE'(col) * W_FRAME_SIZE'(q_chn_words)
                                 + W_FRAME_SIZE'(chn);
`ifdef IFM_BUF_PAD_EN
            logic [W_SIZE-1:0] row;
            assign row = i_ifm_req_row[gi*W_SIZE +: W_SIZE];
            assign lane_pad[gi] = (row >= q_height) || (col >= q_width);
`else
            assign lane_pad[gi] = 1'b0;
`endif
        end
    endgenerate

`ifndef IFM_BUF_PAD_EN
    // Frame bounds and upper row bits only matter for padding.
    logic unused_pad_inputs;
    assign unused_pad_inputs = ^{q_width, q_height, i_ifm_req_row};
`endif

    always_comb begin
        bank_en_d  = '0;
        conflict_d = 1'b0;
        for (int b = 0; b < IFM_BUF_CNT; b++) begin
            bank_addr_d[b] = buf_addr_q[b];
        end
        // Walk from the highest lane down so the lowest-index lane owns a shared bank.
        for (int i = K - 1; i >= 0; i--) begin
            if (i_ifm_req_vld && !lane_pad[i]) begin
                bank_en_d[lane_bank[i]]   = 1'b1;
                bank_addr_d[lane_bank[i]] = lane_addr[i];
            end
        end
        for (int i = 0; i < K; i++) begin
            for (int j = i + 1; j < K; j++) begin
                if (i_ifm_req_vld && !lane_pad[i] && !lane_pad[j] &&
                    (lane_bank[i] == lane_bank[j]) && (lane_addr[i] != lane_addr[j])) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    // Each lane picks its own bank's read data; a losing lane sees the winner's word.
    generate
        for (gi = 0; gi < K; gi++) begin : g_sel
            assign data_d[gi*IFM_DW +: IFM_DW] =
                s2_pad_q[gi] ? '0 : i_buf_rdata[int'(s2_bank_q[gi])*IFM_DW +: IFM_DW];
        end
        for (gi = 0; gi < IFM_BUF_CNT; gi++) begin : g_addr
            assign o_buf_addr[gi*W_FRAME_SIZE +: W_FRAME_SIZE] = buf_addr_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            buf_en_q   <= '0;
            s1_pad_q   <= '0;
            s2_pad_q   <= '0;
            data_vld_q <= 1'b0;
            data_q     <= '0;
            conflict_q <= 1'b0;
            for (int b = 0; b < IFM_BUF_CNT; b++) begin
                buf_addr_q[b] <= '0;
            end
            for (int i = 0; i < K; i++) begin
                s1_bank_q[i] <= '0;
                s2_bank_q[i] <= '0;
            end
        end else begin
            s1_vld_q <= i_ifm_req_vld;
            buf_en_q <= bank_en_d;
            s1_pad_q <= lane_pad;
            for (int b = 0; b < IFM_BUF_CNT; b++) begin
                buf_addr_q[b] <= bank_addr_d[b];
            end
            for (int i = 0; i < K; i++) begin
                s1_bank_q[i] <= lane_bank[i];
                s2_bank_q[i] <= s1_bank_q[i];
            end
            s2_vld_q   <= s1_vld_q;
            s2_pad_q   <= s1_pad_q;
            data_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                data_q <= data_d;
            end
            if (conflict_d) begin
                conflict_q <= 1'b1;
            end
        end
    end

    assign o_buf_en       = buf_en_q;
    assign o_ifm_data_vld = data_vld_q;
    assign o_ifm_data     = data_q;
    assign o_conflict     = conflict_q;

endmodule

// File: tb/tb_ifm_buf_responder.sv
// Self-checking bench for ifm_buf_responder: directed scenarios plus a randomized stream
// checked against a lane-level model of bank selection, arbitration and padding.
module tb_ifm_buf_responder;
    localparam int K            = 3;
    localparam int W_SIZE       = 10;
    localparam int W_CHANNEL    = 10;
    localparam int W_FRAME_SIZE = 14;
    localparam int IFM_DW       = 32;
    localparam int IFM_BUF_CNT  = 4;
    localparam int W_IFM_BUF    = 2;

    logic clk = 1'b0;
    logic rst;
    logic [W_SIZE-1:0]                   q_width;
    logic [W_SIZE-1:0]                   q_height;
    logic [W_CHANNEL-1:0]                q_chn_words;
    logic                                req_vld;
    logic [K*W_SIZE-1:0]                 req_row;
    logic [K*W_SIZE-1:0]                 req_col;
    logic [K*W_CHANNEL-1:0]              req_chn;
    logic [IFM_BUF_CNT-1:0]              o_buf_en;
    logic [IFM_BUF_CNT*W_FRAME_SIZE-1:0] o_buf_addr;
    logic [IFM_BUF_CNT*IFM_DW-1:0]       buf_rdata;
    logic                                o_ifm_data_vld;
    logic [K*IFM_DW-1:0]                 o_ifm_data;
    logic                                o_conflict;

    int total = 0;
    int bad   = 0;
    logic [K*IFM_DW-1:0] held;

    ifm_buf_responder #(
        .K(K), .W_SIZE(W_SIZE), .W_CHANNEL(W_CHANNEL), .W_FRAME_SIZE(W_FRAME_SIZE),
        .IFM_DW(IFM_DW), .IFM_BUF_CNT(IFM_BUF_CNT), .W_IFM_BUF(W_IFM_BUF)
    ) dut (
        .clk(clk), .rst(rst),
        .q_width(q_width), .q_height(q_height), .q_chn_words(q_chn_words),
        .i_ifm_req_vld(req_vld), .i_ifm_req_row(req_row), .i_ifm_req_col(req_col),
        .i_ifm_req_chn(req_chn),
        .o_buf_en(o_buf_en), .o_buf_addr(o_buf_addr), .i_buf_rdata(buf_rdata),
        .o_ifm_data_vld(o_ifm_data_vld), .o_ifm_data(o_ifm_data), .o_conflict(o_conflict)
    );

    always #5 clk = ~clk;

    // Unique content per (bank, address)
    function automatic logic [IFM_DW-1:0] mem_word(input int b, input int a);
        logic [3:0]  bb;
        logic [13:0] aa;
        bb = 4'(b);
        aa = 14'(a);
        return {bb, aa, aa} ^ 32'hC3A5_0F1E;
    endfunction

    // Bank memories with one-cycle registered read
    always @(posedge clk) begin
        for (int b = 0; b < IFM_BUF_CNT; b++) begin
            if (o_buf_en[b])
                buf_rdata[b*IFM_DW +: IFM_DW] <= mem_word(b, int'(o_buf_addr[b*W_FRAME_SIZE +: W_FRAME_SIZE]));
        end
    end

    // Reference: per-lane bank/address, lowest non-pad lane owns each bank
    function automatic void model(output logic [K*IFM_DW-1:0] d, output bit conf,
                                  output logic [IFM_BUF_CNT-1:0] en,
                                  output logic [IFM_BUF_CNT*W_FRAME_SIZE-1:0] a);
        int bank [K];
        int addr [K];
        bit pad [K];
        int r, c, ch, win;
        d = '0; conf = 1'b0; en = '0; a = '0;
        for (int i = 0; i < K; i++) begin
            r  = int'(req_row[i*W_SIZE +: W_SIZE]);
            c  = int'(req_col[i*W_SIZE +: W_SIZE]);
            ch = int'(req_chn[i*W_CHANNEL +: W_CHANNEL]);
            bank[i] = r % IFM_BUF_CNT;
            addr[i] = (c * int'(q_chn_words) + ch) % (1 << W_FRAME_SIZE);
            pad[i]  = 1'b0;
`ifdef IFM_BUF_PAD_EN
            pad[i]  = (r >= int'(q_height)) || (c >= int'(q_width));
`endif
        end
        for (int i = 0; i < K; i++) begin
            if (!pad[i]) begin
                win = i;
                for (int j = i - 1; j >= 0; j--)
                    if (!pad[j] && bank[j] == bank[i]) win = j;
                if (addr[win] != addr[i]) conf = 1'b1;
                en[bank[i]] = 1'b1;
                a[bank[i]*W_FRAME_SIZE +: W_FRAME_SIZE] = W_FRAME_SIZE'(addr[win]);
                d[i*IFM_DW +: IFM_DW] = mem_word(bank[i], addr[win]);
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input int r, input int c, input int ch);
        req_row[i*W_SIZE +: W_SIZE]       = W_SIZE'(r);
        req_col[i*W_SIZE +: W_SIZE]       = W_SIZE'(c);
        req_chn[i*W_CHANNEL +: W_CHANNEL] = W_CHANNEL'(ch);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_vld = 1'b1;
        req_row = K*W_SIZE'($urandom);
        req_col = K*W_SIZE'($urandom);
        req_chn = K*W_CHANNEL'($urandom);
        step();
        step();
        total++; if (o_buf_en !== '0) begin bad++; $display("FAIL reset_en: got %b want 0", o_buf_en); end
        total++; if (o_buf_addr !== '0) begin bad++; $display("FAIL reset_addr: got %h want 0", o_buf_addr); end
        total++; if (o_ifm_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", o_ifm_data); end
        total++; if (o_ifm_data_vld !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", o_ifm_data_vld); end
        total++; if (o_conflict !== 1'b0) begin bad++; $display("FAIL reset_conflict: got %b want 0", o_conflict); end
        rst = 1'b0;
        req_vld = 1'b0;
        held = '0;
        for (int n = 0; n < 4; n++) begin
            step();
            total++; if (o_ifm_data_vld !== 1'b0) begin bad++; $display("FAIL reset_req_ignored c%0d: vld got %b want 0", n, o_ifm_data_vld); end
        end
    endtask

    task automatic test_single();
        logic [K*IFM_DW-1:0] d; bit c; logic [IFM_BUF_CNT-1:0] en; logic [IFM_BUF_CNT*W_FRAME_SIZE-1:0] a;
        q_width = 16; q_height = 16; q_chn_words = 4;
        set_lane(0, 4, 2, 1); set_lane(1, 5, 2, 1); set_lane(2, 6, 2, 1);
        model(d, c, en, a);
        req_vld = 1'b1;
        step();
        req_vld = 1'b0;
        total++; if (o_buf_en !== 4'b0111) begin bad++; $display("FAIL single_en: got %b want 0111", o_buf_en); end
        for (int b = 0; b < 3; b++) begin
            total++;
            if (o_buf_addr[b*W_FRAME_SIZE +: W_FRAME_SIZE] !== 14'd9) begin
                bad++; $display("FAIL single_addr b%0d: got %0d want 9", b, o_buf_addr[b*W_FRAME_SIZE +: W_FRAME_SIZE]);
            end
        end
        step();
        total++; if (o_ifm_data_vld !== 1'b0) begin bad++; $display("FAIL single_early_vld: got %b want 0", o_ifm_data_vld); end
        step();
        total++; if (o_ifm_data_vld !== 1'b1) begin bad++; $display("FAIL single_vld: got %b want 1", o_ifm_data_vld); end
        total++; if (o_ifm_data !== d) begin bad++; $display("FAIL single_data: got %h want %h", o_ifm_data, d); end
        held = d;
        step();
        total++; if (o_ifm_data_vld !== 1'b0 || o_ifm_data !== held) begin
            bad++; $display("FAIL single_hold: vld %b data %h want 0 / %h", o_ifm_data_vld, o_ifm_data, held);
        end
    endtask

    task automatic test_back_to_back();
        logic [K*IFM_DW-1:0] d; bit c; logic [IFM_BUF_CNT-1:0] en; logic [IFM_BUF_CNT*W_FRAME_SIZE-1:0] a;
        logic [K*IFM_DW-1:0] pd [1:3];
        bit pv [1:3];
        bit v_now;
        q_width = 64; q_height = 64; q_chn_words = 3;
        for (int k = 1; k <= 3; k++) begin pv[k] = 1'b0; pd[k] = '0; end
        for (int n = 0; n < 13; n++) begin
            if (n < 10) begin
                for (int i = 0; i < K; i++) set_lane(i, i, n, $urandom_range(0, 2));
                req_vld = 1'b1;
                model(d, c, en, a);
            end else begin
                req_vld = 1'b0;
                d = '0;
            end
            v_now = req_vld;
            step();
            pv[3] = pv[2]; pd[3] = pd[2];
            pv[2] = pv[1]; pd[2] = pd[1];
            pv[1] = v_now; pd[1] = d;
            if (pv[3]) held = pd[3];
            total++; if (o_ifm_data_vld !== pv[3]) begin bad++; $display("FAIL b2b_vld c%0d: got %b want %b", n, o_ifm_data_vld, pv[3]); end
            total++; if (o_ifm_data !== held) begin bad++; $display("FAIL b2b_data c%0d: got %h want %h", n, o_ifm_data, held); end
        end
        req_vld = 1'b0;
    endtask

    task automatic test_broadcast();
        logic [K*IFM_DW-1:0] d; bit c; logic [IFM_BUF_CNT-1:0] en; logic [IFM_BUF_CNT*W_FRAME_SIZE-1:0] a;
        q_width = 16; q_height = 16; q_chn_words = 4;
        set_lane(0, 3, 5, 2); set_lane(1, 3, 5, 2); set_lane(2, 0, 1, 0);
        model(d, c, en, a);
        req_vld = 1'b1;
        step();
        req_vld = 1'b0;
        total++; if (o_buf_en !== 4'b1001) begin bad++; $display("FAIL bcast_en: got %b want 1001", o_buf_en); end
        total++; if (o_buf_addr[3*W_FRAME_SIZE +: W_FRAME_SIZE] !== 14'd22) begin
            bad++; $display("FAIL bcast_addr: got %0d want 22", o_buf_addr[3*W_FRAME_SIZE +: W_FRAME_SIZE]);
        end
        total++; if (o_conflict !== 1'b0) begin bad++; $display("FAIL bcast_conflict: got %b want 0", o_conflict); end
        step();
        step();
        total++; if (o_ifm_data_vld !== 1'b1) begin bad++; $display("FAIL bcast_vld: got %b want 1", o_ifm_data_vld); end
        total++; if (o_ifm_data[IFM_DW +: IFM_DW] !== mem_word(3, 22) || o_ifm_data[0 +: IFM_DW] !== mem_word(3, 22)) begin
            bad++; $display("FAIL bcast_lanes: got %h want lanes0/1=%h", o_ifm_data, mem_word(3, 22));
        end
        total++; if (o_ifm_data !== d) begin bad++; $display("FAIL bcast_data: got %h want %h", o_ifm_data, d); end
        held = d;
    endtask

    task automatic test_pad();
        logic [K*IFM_DW-1:0] d; bit c; logic [IFM_BUF_CNT-1:0] en; logic [IFM_BUF_CNT*W_FRAME_SIZE-1:0] a;
        logic [IFM_BUF_CNT-1:0] en_want;
        logic [IFM_DW-1:0] lane0_want;
`ifdef IFM_BUF_PAD_EN
        en_want = 4'b0011; lane0_want = '0;
`else
        en_want = 4'b1011; lane0_want = mem_word(3, 2);
`endif
        q_width = 16; q_height = 8; q_chn_words = 2;
        set_lane(0, 1023, 1, 0); set_lane(1, 0, 1, 0); set_lane(2, 1, 1, 0);
        model(d, c, en, a);
        req_vld = 1'b1;
        step();
        req_vld = 1'b0;
        total++; if (o_buf_en !== en_want) begin bad++; $display("FAIL pad_en: got %b want %b", o_buf_en, en_want); end
        total++; if (o_conflict !== 1'b0) begin bad++; $display("FAIL pad_conflict: got %b want 0", o_conflict); end
        step();
        step();
        total++; if (o_ifm_data_vld !== 1'b1) begin bad++; $display("FAIL pad_vld: got %b want 1", o_ifm_data_vld); end
        total++; if (o_ifm_data[0 +: IFM_DW] !== lane0_want) begin
            bad++; $display("FAIL pad_lane0: got %h want %h", o_ifm_data[0 +: IFM_DW], lane0_want);
        end
        total++; if (o_ifm_data !== d) begin bad++; $display("FAIL pad_data: got %h want %h", o_ifm_data, d); end
        held = d;
    endtask

    task automatic test_conflict();
        logic [K*IFM_DW-1:0] d; bit c; logic [IFM_BUF_CNT-1:0] en; logic [IFM_BUF_CNT*W_FRAME_SIZE-1:0] a;
        q_width = 16; q_height = 16; q_chn_words = 1;
        set_lane(0, 1, 0, 0); set_lane(1, 5, 3, 0); set_lane(2, 2, 0, 0);
        model(d, c, en, a);
        req_vld = 1'b1;
        step();
        req_vld = 1'b0;
        total++; if (o_conflict !== 1'b1) begin bad++; $display("FAIL conflict_set: got %b want 1", o_conflict); end
        total++; if (o_buf_addr[1*W_FRAME_SIZE +: W_FRAME_SIZE] !== 14'd0) begin
            bad++; $display("FAIL conflict_winner_addr: got %0d want 0", o_buf_addr[1*W_FRAME_SIZE +: W_FRAME_SIZE]);
        end
        step();
        step();
        total++; if (o_ifm_data_vld !== 1'b1) begin bad++; $display("FAIL conflict_vld: got %b want 1", o_ifm_data_vld); end
        total++; if (o_ifm_data[IFM_DW +: IFM_DW] !== mem_word(1, 0)) begin
            bad++; $display("FAIL conflict_lane1: got %h want %h", o_ifm_data[IFM_DW +: IFM_DW], mem_word(1, 0));
        end
        total++; if (o_ifm_data !== d) begin bad++; $display("FAIL conflict_data: got %h want %h", o_ifm_data, d); end
        for (int n = 0; n < 5; n++) step();
        total++; if (o_conflict !== 1'b1) begin bad++; $display("FAIL conflict_sticky: got %b want 1", o_conflict); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        held = '0;
        total++; if (o_conflict !== 1'b0 || o_ifm_data !== '0) begin
            bad++; $display("FAIL conflict_clear: conflict %b data %h want 0/0", o_conflict, o_ifm_data);
        end
    endtask

    task automatic test_reset_mid();
        logic [K*IFM_DW-1:0] d; bit c; logic [IFM_BUF_CNT-1:0] en; logic [IFM_BUF_CNT*W_FRAME_SIZE-1:0] a;
        q_width = 16; q_height = 16; q_chn_words = 1;
        set_lane(0, 0, 3, 0); set_lane(1, 1, 3, 0); set_lane(2, 2, 3, 0);
        req_vld = 1'b1;
        step();
        req_vld = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        total++; if (o_ifm_data_vld !== 1'b0) begin bad++; $display("FAIL rstmid_vld: got %b want 0", o_ifm_data_vld); end
        total++; if (o_ifm_data !== '0 || o_buf_en !== '0 || o_buf_addr !== '0 || o_conflict !== 1'b0) begin
            bad++; $display("FAIL rstmid_outputs: data %h en %b addr %h conflict %b want all 0", o_ifm_data, o_buf_en, o_buf_addr, o_conflict);
        end
        held = '0;
        set_lane(0, 2, 7, 0); set_lane(1, 3, 4, 0); set_lane(2, 0, 9, 0);
        model(d, c, en, a);
        req_vld = 1'b1;
        step();
        req_vld = 1'b0;
        total++; if (o_buf_en !== en) begin bad++; $display("FAIL rstmid_en: got %b want %b", o_buf_en, en); end
        step();
        total++; if (o_ifm_data_vld !== 1'b0) begin bad++; $display("FAIL rstmid_early: got %b want 0", o_ifm_data_vld); end
        step();
        total++; if (o_ifm_data_vld !== 1'b1 || o_ifm_data !== d) begin
            bad++; $display("FAIL rstmid_resp: vld %b data %h want 1 / %h", o_ifm_data_vld, o_ifm_data, d);
        end
        held = d;
    endtask

    task automatic test_random();
        logic [K*IFM_DW-1:0] d; bit c; logic [IFM_BUF_CNT-1:0] en; logic [IFM_BUF_CNT*W_FRAME_SIZE-1:0] a;
        logic [K*IFM_DW-1:0] pd [1:3];
        bit pv [1:3];
        bit v_now, conf_exp;
        logic [IFM_BUF_CNT*W_FRAME_SIZE-1:0] addr_held;
        rst = 1'b1;
        req_vld = 1'b0;
        step();
        rst = 1'b0;
        held = '0; addr_held = '0; conf_exp = 1'b0;
        for (int k = 1; k <= 3; k++) begin pv[k] = 1'b0; pd[k] = '0; end
        for (int n = 0; n < 400; n++) begin
            if (n % 25 == 0) begin
                q_width = W_SIZE'($urandom_range(1, 32));
                q_height = W_SIZE'($urandom_range(1, 32));
                q_chn_words = W_CHANNEL'($urandom_range(1, 8));
            end
            if (n < 390 && $urandom_range(0, 9) < 7) begin
                for (int i = 0; i < K; i++)
                    set_lane(i, $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) begin
                    req_row[W_SIZE +: W_SIZE] = req_row[0 +: W_SIZE];
                    req_col[W_SIZE +: W_SIZE] = req_col[0 +: W_SIZE];
                    req_chn[W_CHANNEL +: W_CHANNEL] = req_chn[0 +: W_CHANNEL];
                end
                req_vld = 1'b1;
                model(d, c, en, a);
            end else begin
                req_vld = 1'b0;
                req_row = K*W_SIZE'($urandom);
                d = '0; c = 1'b0; en = '0; a = '0;
            end
            v_now = req_vld;
            step();
            pv[3] = pv[2]; pd[3] = pd[2];
            pv[2] = pv[1]; pd[2] = pd[1];
            pv[1] = v_now; pd[1] = d;
            if (pv[3]) held = pd[3];
            conf_exp = conf_exp | c;
            for (int b = 0; b < IFM_BUF_CNT; b++)
                if (en[b]) addr_held[b*W_FRAME_SIZE +: W_FRAME_SIZE] = a[b*W_FRAME_SIZE +: W_FRAME_SIZE];
            total++; if (o_buf_en !== en) begin bad++; $display("FAIL rnd_en c%0d: got %b want %b", n, o_buf_en, en); end
            total++; if (o_buf_addr !== addr_held) begin bad++; $display("FAIL rnd_addr c%0d: got %h want %h", n, o_buf_addr, addr_held); end
            total++; if (o_conflict !== conf_exp) begin bad++; $display("FAIL rnd_conflict c%0d: got %b want %b", n, o_conflict, conf_exp); end
            total++; if (o_ifm_data_vld !== pv[3]) begin bad++; $display("FAIL rnd_vld c%0d: got %b want %b", n, o_ifm_data_vld, pv[3]); end
            total++; if (o_ifm_data !== held) begin bad++; $display("FAIL rnd_data c%0d: got %h want %h", n, o_ifm_data, held); end
        end
        req_vld = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_vld = 1'b0;
        req_row = '0; req_col = '0; req_chn = '0;
        q_width = 16; q_height = 16; q_chn_words = 1;
        held = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_broadcast();
        test_pad();
        test_conflict();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
